// File: rtl/jump_ctrl_pkg.sv
// Shared types and default sizes for the jump_ctrl control-flow resolver.
package jump_ctrl_pkg;

   localparam int unsigned PC_W_DEF      = 6;
   localparam int unsigned LUT_AW_DEF    = 4;
   localparam int unsigned RAS_DEPTH_DEF = 4;

   // Encodings 6 and 7 have no enumerator and fall through to NONE.
   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_JMP  = 3'd1,
      OP_BEQZ = 3'd2,
      OP_BNEZ = 3'd3,
      OP_CALL = 3'd4,
      OP_RET  = 3'd5
   } br_op_t;

endpackage

// File: rtl/jump_ctrl_ret_stack.sv
// Return-address stack: push is dropped when full, pop is ignored when empty.
module ret_stack #(
   parameter int unsigned W     = 6,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [W-1:0]               din_i,
   output logic [W-1:0]               top_o,
   output logic [$clog2(DEPTH):0]     depth_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int unsigned DW = $clog2(DEPTH) + 1;
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [DW-1:0] cnt_q, cnt_d;

   assign full_o  = (cnt_q == DW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign depth_o = cnt_q;
   assign top_o   = mem_q[AW'(cnt_q - DW'(1))];

   always_comb begin
      cnt_d = cnt_q;
      if (push_i && !full_o)
         cnt_d = cnt_q + DW'(1);
      else if (pop_i && !empty_o)
         cnt_d = cnt_q - DW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         mem_q <= '{default: '0};
      end else begin
         cnt_q <= cnt_d;
         if (push_i && !full_o)
            mem_q[AW'(cnt_q)] <= din_i;
      end
   end

endmodule

// File: rtl/jump_ctrl.sv
// Branch target resolver: target LUT, zero flag and optional return-address stack.
// Define JUMP_CTRL_RAS_EN to build in CALL/RET stack support.
module jump_ctrl
   import jump_ctrl_pkg::*;
#(
   parameter int unsigned PC_W      = PC_W_DEF,
   parameter int unsigned LUT_AW    = LUT_AW_DEF,
   parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [PC_W-1:0]             pc,
   input  logic [2:0]                  op,
   input  logic [LUT_AW-1:0]           lut_idx,
   input  logic                        alu_zero,
   input  logic                        flag_we,
   input  logic                        lut_we,
   input  logic [LUT_AW-1:0]           lut_waddr,
   input  logic [PC_W-1:0]             lut_wdata,
   output logic [PC_W-1:0]             nextPC,
   output logic                        jump,
   output logic [$clog2(RAS_DEPTH):0]  ras_depth,
   output logic                        ras_ovf,
   output logic                        ras_unf
);

   logic [PC_W-1:0] lut_q [2**LUT_AW];
   logic            zflag_q;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] lut_tgt;
   logic            is_call, is_ret;

   assign pc_inc  = pc + PC_W'(1);
   assign lut_tgt = lut_q[lut_idx];
   assign is_call = (op == OP_CALL);
   assign is_ret  = (op == OP_RET);

`ifdef JUMP_CTRL_RAS_EN
   logic            ras_push, ras_pop, ras_full, ras_empty;
   logic [PC_W-1:0] ras_top;
   logic            ovf_q, ovf_d, unf_q, unf_d;

   ret_stack #(
      .W     (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ret_stack (
      .clk     (clk),
      .reset   (reset),
      .push_i  (ras_push),
      .pop_i   (ras_pop),
      .din_i   (pc_inc),
      .top_o   (ras_top),
      .depth_o (ras_depth),
      .full_o  (ras_full),
      .empty_o (ras_empty)
   );

   assign ras_push = is_call;
   assign ras_pop  = is_ret && !ras_empty;
   assign ovf_d    = ovf_q | (is_call && ras_full);
   assign unf_d    = unf_q | (is_ret && ras_empty);
   assign ras_ovf  = ovf_q;
   assign ras_unf  = unf_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end
`else
   assign ras_depth = '0;
   assign ras_ovf   = 1'b0;
   assign ras_unf   = 1'b0;
`endif

   always_comb begin
      jump   = 1'b0;
      nextPC = pc_inc;
      case (br_op_t'(op))
         OP_JMP, OP_CALL: begin
            jump   = 1'b1;
            nextPC = lut_tgt;
         end
         OP_BEQZ: if (zflag_q) begin
            jump   = 1'b1;
            nextPC = lut_tgt;
         end
         OP_BNEZ: if (!zflag_q) begin
            jump   = 1'b1;
            nextPC = lut_tgt;
         end
`ifdef JUMP_CTRL_RAS_EN
         OP_RET: if (!ras_empty) begin
            jump   = 1'b1;
            nextPC = ras_top;
         end
`endif
         default: ;
      endcase
   end

   // Reads above see pre-edge LUT and flag contents, so same-cycle writes appear next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lut_q   <= '{default: '0};
         zflag_q <= 1'b0;
      end else begin
         if (lut_we)
            lut_q[lut_waddr] <= lut_wdata;
         if (flag_we)
            zflag_q <= alu_zero;
      end
   end

endmodule

// File: tb/tb_jump_ctrl.sv
// Scoreboard bench for jump_ctrl; expectations follow JUMP_CTRL_RAS_EN as built.
module tb_jump_ctrl;
   import jump_ctrl_pkg::*;

   localparam int PC_W = 6, LUT_AW = 4, RAS_DEPTH = 4;
   localparam int DW = $clog2(RAS_DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [PC_W-1:0]   pc = '0;
   logic [2:0]        op = '0;
   logic [LUT_AW-1:0] lut_idx = '0;
   logic              alu_zero = 1'b0, flag_we = 1'b0, lut_we = 1'b0;
   logic [LUT_AW-1:0] lut_waddr = '0;
   logic [PC_W-1:0]   lut_wdata = '0;
   logic [PC_W-1:0]   nextPC;
   logic              jump;
   logic [DW-1:0]     ras_depth;
   logic              ras_ovf, ras_unf;

   jump_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW), .RAS_DEPTH(RAS_DEPTH)) dut (
      .clk(clk), .reset(reset), .pc(pc), .op(op), .lut_idx(lut_idx),
      .alu_zero(alu_zero), .flag_we(flag_we), .lut_we(lut_we),
      .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .nextPC(nextPC),
      .jump(jump), .ras_depth(ras_depth), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            j;
      logic [PC_W-1:0] n;
      logic [DW-1:0]   d;
      logic            ovf;
      logic            unf;
   } exp_t;

   exp_t sb[$];
   int   checks = 0, failures = 0;

   logic [PC_W-1:0] m_lut [16];
   logic            m_z;
   logic [PC_W-1:0] m_stk [RAS_DEPTH];
   int              m_cnt;
   logic            m_ovf, m_unf;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("jump",      32'(jump),      32'(e.j));
         chk("nextPC",    32'(nextPC),    32'(e.n));
         chk("ras_depth", 32'(ras_depth), 32'(e.d));
         chk("ras_ovf",   32'(ras_ovf),   32'(e.ovf));
         chk("ras_unf",   32'(ras_unf),   32'(e.unf));
      end
   end

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m_lut[i] = '0;
      for (int i = 0; i < RAS_DEPTH; i++) m_stk[i] = '0;
      m_z = 1'b0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   function automatic exp_t model_exp();
      exp_t e;
      logic [PC_W-1:0] inc;
      inc   = pc + PC_W'(1);
      e.j   = 1'b0;
      e.n   = inc;
      e.d   = DW'(m_cnt);
      e.ovf = m_ovf;
      e.unf = m_unf;
      case (op)
         3'd1, 3'd4: begin e.j = 1'b1; e.n = m_lut[lut_idx]; end
         3'd2: if (m_z)  begin e.j = 1'b1; e.n = m_lut[lut_idx]; end
         3'd3: if (!m_z) begin e.j = 1'b1; e.n = m_lut[lut_idx]; end
`ifdef JUMP_CTRL_RAS_EN
         3'd5: if (m_cnt > 0) begin e.j = 1'b1; e.n = m_stk[m_cnt-1]; end
`endif
         default: ;
      endcase
      return e;
   endfunction

   task automatic model_step();
      logic [PC_W-1:0] inc;
      inc = pc + PC_W'(1);
`ifdef JUMP_CTRL_RAS_EN
      if (op == 3'd4) begin
         if (m_cnt < RAS_DEPTH) begin m_stk[m_cnt] = inc; m_cnt++; end
         else m_ovf = 1'b1;
      end else if (op == 3'd5) begin
         if (m_cnt > 0) m_cnt--;
         else m_unf = 1'b1;
      end
`endif
      if (lut_we)  m_lut[lut_waddr] = lut_wdata;
      if (flag_we) m_z = alu_zero;
   endtask

   task automatic drive(input logic [2:0] o, input int idx = 0, input int p = 0,
                        input logic az = 0, input logic fwe = 0, input logic lwe = 0,
                        input int wa = 0, input int wd = 0);
      @(posedge clk); #1;
      op = o; lut_idx = LUT_AW'(idx); pc = PC_W'(p);
      alu_zero = az; flag_we = fwe; lut_we = lwe;
      lut_waddr = LUT_AW'(wa); lut_wdata = PC_W'(wd);
      sb.push_back(model_exp());
      model_step();
   endtask

   task automatic idle_inputs();
      op = 3'd0; flag_we = 1'b0; lut_we = 1'b0;
   endtask

   // Reset is raised mid-cycle so the sampled outputs prove it acts asynchronously.
   task automatic apply_reset(input logic [2:0] o, input int idx, input int p);
      @(posedge clk); #1;
      idle_inputs();
      op = o; lut_idx = LUT_AW'(idx); pc = PC_W'(p);
      reset = 1'b1;
      model_clear();
      sb.push_back(model_exp());
      @(posedge clk); #1;
      reset = 1'b0;
      idle_inputs();
   endtask

   initial begin
      model_clear();
      apply_reset(3'd0, 0, 0);
      drive(3'd0, 0, 0, 0, 0, 1, 3, 42);
      drive(3'd1, 3, 10);
      drive(3'd0, 3, 10);
      drive(3'd2, 3, 12, 1, 1);
      drive(3'd2, 3, 12);
      drive(3'd3, 3, 12);
      drive(3'd3, 3, 12, 0, 1);
      drive(3'd3, 3, 12);
      drive(3'd1, 3, 0, 0, 0, 1, 3, 7);
      drive(3'd1, 3, 0);
      drive(3'd6, 3, 17);
      drive(3'd7, 3, 18);
      drive(3'd0, 0, 0, 0, 0, 1, 1, 20);
      drive(3'd0, 0, 0, 0, 0, 1, 2, 30);
      drive(3'd4, 1, 5);
      drive(3'd4, 2, 21);
      drive(3'd0, 0, 30);
      drive(3'd5, 0, 30);
      drive(3'd5, 0, 22);
      drive(3'd0, 0, 6);
      for (int i = 0; i < 5; i++) drive(3'd4, 1, 40 + i);
      drive(3'd0, 0, 50);
      for (int i = 0; i < 5; i++) drive(3'd5, 0, 21 + i);
      drive(3'd0, 0, 30);
      drive(3'd4, 1, 63);
      drive(3'd5, 0, 20);
      drive(3'd0, 0, 0, 0, 0, 1, 3, 42);
      drive(3'd4, 1, 8);
      apply_reset(3'd1, 3, 9);
      drive(3'd5, 0, 20);
      drive(3'd1, 3, 20);
      drive(3'd2, 3, 20);
      for (int i = 0; i < 60; i++)
         drive(3'($urandom_range(0, 7)), $urandom_range(0, 15), $urandom_range(0, 63),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 15), $urandom_range(0, 63));
      @(posedge clk); #1;
      idle_inputs();
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jump_ctrl.md
# jump_ctrl

Control-flow resolver that produces the `nextPC` and `jump` inputs for the program counter register. Each cycle it takes the current `pc` and the decoded branch opcode, and resolves the target through a loadable 16-entry target lookup table. It holds a registered zero flag for conditional branches and a small return-address stack for CALL/RET. It sits between instruction decode/ALU and the PC register, and its outputs are valid combinationally within the same cycle the instruction is presented.

## Interface
- `PC_W`, default 6: PC and target width.
- `LUT_AW`, default 4: target LUT address width (2^LUT_AW entries).
- `RAS_DEPTH`, default 4: return-address stack entries.
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `pc` in PC_W: current PC from the PC register.
- `op` in 3: branch opcode: NONE=0, JMP=1, BEQZ=2, BNEZ=3, CALL=4, RET=5; 6 and 7 are treated as NONE.
- `lut_idx` in LUT_AW: target LUT index for JMP, BEQZ, BNEZ and CALL.
- `alu_zero` in 1: ALU zero result.
- `flag_we` in 1: capture `alu_zero` into the flag register.
- `lut_we` in 1: LUT write enable.
- `lut_waddr` in LUT_AW: LUT write address.
- `lut_wdata` in PC_W: LUT write data.
- `nextPC` out PC_W: jump target, or pc+1 when no jump is taken.
- `jump` out 1: take `nextPC` this cycle.
- `ras_depth` out $clog2(RAS_DEPTH)+1: current number of stack entries.
- `ras_ovf` out 1: sticky error, CALL issued while the stack was full.
- `ras_unf` out 1: sticky error, RET issued while the stack was empty.

## Operation
- State:
  - `lut[2^LUT_AW]`
  - `zflag`
  - RAS entries
  - RAS pointer
  - sticky error bits
- Reset values:
  - All LUT entries are 0.
  - `zflag` is 0.
  - The RAS is empty, so `ras_depth` is 0.
  - `ras_ovf` and `ras_unf` are 0.
  - With op=NONE, the outputs are jump=0 and nextPC=pc+1.
- Target resolution, combinational:
  - JMP: jump=1, nextPC=lut[lut_idx].
  - BEQZ: jump=zflag, target lut[lut_idx].
  - BNEZ: jump=!zflag, target lut[lut_idx].
  - CALL: jump=1, nextPC=lut[lut_idx]; push (pc+1) mod 2^PC_W at the clock edge.
  - RET with a non-empty stack: jump=1, nextPC=top of stack; pop at the clock edge.
  - RET with an empty stack: jump=0, nextPC=pc+1, set `ras_unf`, pointer unchanged.
  - NONE, 6, 7, or a branch not taken: jump=0, nextPC=pc+1.
- Return address wraps: pc=63 pushes 0.
- CALL with a full stack: the jump is still taken, the push is dropped, the contents are unchanged, and `ras_ovf` is set.
- `ras_ovf` and `ras_unf` clear only on reset.
- `zflag` loads `alu_zero` on the clock edge when `flag_we`=1.
- LUT write: `lut[lut_waddr]` <= `lut_wdata` on the clock edge when `lut_we`=1.
- All arithmetic is unsigned, PC_W bits, modulo 2^PC_W.

## Timing
- `jump` and `nextPC` have zero-cycle latency: they are a combinational function of the inputs and current state, and the PC register samples them on the same edge.
- State updates (push, pop, flag, LUT, error bits) occur on the rising edge in the same cycle the instruction is presented.
- Flag written in the same cycle as a BEQZ/BNEZ: the branch uses the old `zflag`, and the new value is visible next cycle.
- LUT written at the same index read in the same cycle: the read returns the old entry, and the new entry is visible next cycle.
- Back-to-back CALL then RET: RET returns the address pushed on the previous edge.
- Reset asserted mid-sequence: all state clears asynchronously, and the outputs immediately reflect the empty stack and zero LUT.

## Configuration
- `JUMP_CTRL_RAS_EN` defined: the RAS is compiled in and CALL/RET behave as specified above.
- `JUMP_CTRL_RAS_EN` undefined, no stack storage:
  - CALL behaves exactly as JMP.
  - RET behaves as NONE.
  - `ras_depth`, `ras_ovf` and `ras_unf` are tied to 0.

## Structure
- `jump_ctrl_pkg` holds:
  - the `op` enum typedef (`br_op_t`) with encodings 0–5;
  - the `PC_W` and `LUT_AW` default constants.
- Sub-module `ret_stack`:
  - parameterised by width and depth;
  - push/pop inputs, `top` output, `depth` output, full/empty outputs;
  - instantiated only under `JUMP_CTRL_RAS_EN`.
- Top level holds the LUT, `zflag`, the sticky error bits, and the target multiplexer.

## Test plan
- LUT and JMP:
  - Reset, then write lut[3]=42.
  - Next cycle, op=JMP, lut_idx=3, pc=10 -> jump=1, nextPC=42.
  - op=NONE -> jump=0, nextPC=11.
- Conditional branches with flag hazard:
  - flag_we=1 with alu_zero=1, and BEQZ in the same cycle -> jump=0 (old flag).
  - Next cycle, BEQZ -> jump=1; BNEZ -> jump=0.
- CALL/RET nesting, with lut[1]=20 and lut[2]=30:
  - CALL at pc=5, then CALL at pc=21 -> ras_depth=2.
  - First RET -> nextPC=22; second RET -> nextPC=6; ras_depth returns to 0.
- Stack boundaries:
  - Five CALLs with RAS_DEPTH=4 -> the fifth jumps, ras_ovf=1, ras_depth stays 4.
  - After draining, RET on an empty stack -> jump=0, ras_unf=1.
- Wrap and reset:
  - CALL at pc=63, then RET -> nextPC=0.
  - Assert reset between a CALL and a RET -> ras_depth=0, the RET gives jump=0, lut[3] reads 0.
- Macro off (build without `JUMP_CTRL_RAS_EN`):
  - CALL with lut_idx=1 -> nextPC=20, ras_depth=0.
  - RET -> jump=0, nextPC=pc+1.
